// File: rtl/dr_pkg.sv
// Dual-rail coding helpers and FSM state types shared by the dual-rail FIFO blocks.
// One data bit travels on a rail pair: [1] = true rail, [0] = false rail.
package dr_pkg;

  localparam logic [1:0] DR_T    = 2'b10;
  localparam logic [1:0] DR_F    = 2'b01;
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic {
    IN_WAIT_DATA,
    IN_WAIT_SPACER
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_WAIT_ACK,
    OUT_WAIT_REL
  } out_state_t;

  // Binary bit -> rail pair.
  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_T : DR_F;
  endfunction

  // Rail pair -> binary bit; only meaningful for a valid codeword pair.
  function automatic logic dr_decode(input logic [1:0] p);
    return (p == DR_T);
  endfunction

  // Exactly one rail high.
  function automatic logic dr_is_codeword(input logic [1:0] p);
    return (p == DR_T) || (p == DR_F);
  endfunction

  // Both rails low.
  function automatic logic dr_is_spacer(input logic [1:0] p);
    return (p == DR_NULL);
  endfunction

  // Both rails high: never legal on the wire.
  function automatic logic dr_has_illegal(input logic [1:0] p);
    return (p == DR_ILL);
  endfunction

endpackage

// File: rtl/est_sync_fifo_mem.sv
// Binary storage for the dual-rail FIFO: DEPTH x WIDTH circular buffer with
// wrapping pointers, occupancy count and a reset-time token preload.
// Caller guarantees push only when not full and pop only when not empty.
module est_sync_fifo_mem #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      DEPTH        = 4,
  parameter int unsigned      RESET_TOKENS = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned      AW      = $clog2(DEPTH);
  localparam int unsigned      CW      = AW + 1;
  localparam logic [AW-1:0]    WR_INIT = AW'(RESET_TOKENS % DEPTH);
  localparam logic [CW-1:0]    CNT_INIT = CW'(RESET_TOKENS);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset re-applies the preload tokens at the head of the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ((i + 1) <= RESET_TOKENS) ? RESET_VALUE : '0;
      end
      wr_ptr_q <= WR_INIT;
      rd_ptr_q <= '0;
      count_q  <= CNT_INIT;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/est_sync_dr_fifo.sv
// Clocked dual-rail FIFO: 4-phase return-to-zero handshakes on both sides,
// binary storage inside, sticky detection of illegal (11) rail pairs on input.
module est_sync_dr_fifo
  import dr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      DEPTH        = 4,
  parameter int unsigned      RESET_TOKENS = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*WIDTH-1:0]     data_in,
  output logic                   ack_ant,
  output logic [2*WIDTH-1:0]     data_out,
  input  logic                   ack_next,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_illegal
);

  localparam int unsigned   CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [2*WIDTH-1:0] SPACER = {WIDTH{DR_NULL}};

  in_state_t          in_state_q, in_state_d;
  out_state_t         out_state_q, out_state_d;
  logic               ack_ant_q, ack_ant_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] data_out_q, data_out_d;

  logic               in_codeword, in_spacer, in_illegal;
  logic [WIDTH-1:0]   in_word;
  logic [WIDTH-1:0]   head_word;
  logic [2*WIDTH-1:0] head_rails;
  logic               push, pop;
  logic               full, not_empty;

  est_sync_fifo_mem #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .RESET_TOKENS (RESET_TOKENS),
    .RESET_VALUE  (RESET_VALUE)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_word),
    .pop   (pop),
    .rdata (head_word),
    .count (count)
  );

  // Full is judged on the pre-pop count, so a push never lands on the pop edge of a full FIFO.
  assign full      = (count == FULL_COUNT);
  assign not_empty = (count != '0);

  // Classify the input word, decode it to binary and encode the FIFO head onto rails.
  always_comb begin
    in_codeword = 1'b1;
    in_spacer   = 1'b1;
    in_illegal  = 1'b0;
    in_word     = '0;
    head_rails  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      in_codeword = in_codeword & dr_is_codeword(data_in[2*i +: 2]);
      in_spacer   = in_spacer   & dr_is_spacer(data_in[2*i +: 2]);
      in_illegal  = in_illegal  | dr_has_illegal(data_in[2*i +: 2]);
      in_word[i]  = dr_decode(data_in[2*i +: 2]);
      head_rails[2*i +: 2] = dr_encode(head_word[i]);
    end
  end

  // Input handshake: capture a complete codeword, then wait for the return to spacer.
  always_comb begin
    in_state_d = in_state_q;
    ack_ant_d  = ack_ant_q;
    err_d      = err_q;
    push       = 1'b0;
    case (in_state_q)
      IN_WAIT_DATA: begin
        if (in_illegal) begin
          err_d = 1'b1;
        end else if (in_codeword && !full) begin
          push       = 1'b1;
          ack_ant_d  = 1'b1;
          in_state_d = IN_WAIT_SPACER;
        end
      end
      IN_WAIT_SPACER: begin
        if (in_spacer) begin
          ack_ant_d  = 1'b0;
          in_state_d = IN_WAIT_DATA;
        end
      end
      default: begin
        ack_ant_d  = 1'b0;
        in_state_d = IN_WAIT_DATA;
      end
    endcase
  end

  // Output handshake: present the head, pop it on ack, hold spacer until ack is released.
  always_comb begin
    out_state_d = out_state_q;
    data_out_d  = data_out_q;
    pop         = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (not_empty) begin
          data_out_d  = head_rails;
          out_state_d = OUT_WAIT_ACK;
        end
      end
      OUT_WAIT_ACK: begin
        if (ack_next) begin
          pop         = 1'b1;
          data_out_d  = SPACER;
          out_state_d = OUT_WAIT_REL;
        end
      end
      OUT_WAIT_REL: begin
        if (!ack_next) begin
          out_state_d = OUT_IDLE;
        end
      end
      default: begin
        data_out_d  = SPACER;
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  // Handshake state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_WAIT_DATA;
      out_state_q <= OUT_IDLE;
      ack_ant_q   <= 1'b0;
      err_q       <= 1'b0;
      data_out_q  <= SPACER;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      ack_ant_q   <= ack_ant_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
    end
  end

  assign ack_ant     = ack_ant_q;
  assign data_out    = data_out_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_est_sync_dr_fifo.sv
// Bench for est_sync_dr_fifo: directed handshakes plus random traffic checked
// against a token-queue model of the FIFO.
module tb_est_sync_dr_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       ack_ant;
  logic [7:0] data_out;
  logic       ack_next;
  logic [2:0] count;
  logic       err_illegal;

  logic [7:0] z_data_in;
  logic       z_ack_ant;
  logic [7:0] z_data_out;
  logic       z_ack_next;
  logic [2:0] z_count;
  logic       z_err_illegal;

  always #5 clk = ~clk;

  est_sync_dr_fifo #(
    .WIDTH(4), .DEPTH(4), .RESET_TOKENS(1), .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ack_ant(ack_ant),
    .data_out(data_out), .ack_next(ack_next), .count(count),
    .err_illegal(err_illegal)
  );

  est_sync_dr_fifo #(
    .WIDTH(4), .DEPTH(4), .RESET_TOKENS(0), .RESET_VALUE(4'h0)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .data_in(z_data_in), .ack_ant(z_ack_ant),
    .data_out(z_data_out), .ack_next(z_ack_next), .count(z_count),
    .err_illegal(z_err_illegal)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [3:0]  model_q[$];
  logic        model_err;

  function automatic logic [7:0] enc(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic is_cw(input logic [7:0] r);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ((r[2*i+1] ^ r[2*i]) == 1'b0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Consumer side: take the head token through a full 4-phase handshake.
  task automatic recv(input string tag);
    int unsigned n;
    logic [3:0]  exp;
    n = 0;
    while (!is_cw(data_out) && n < 20) begin
      step();
      n++;
    end
    chk({tag, " present"}, (n < 20), 1);
    exp = model_q.pop_front();
    chk({tag, " data"}, data_out, enc(exp));
    step();
    chk({tag, " data stable"}, data_out, enc(exp));
    ack_next = 1'b1;
    step();
    chk({tag, " spacer"}, data_out, 8'h00);
    chk({tag, " count after pop"}, count, model_q.size());
    ack_next = 1'b0;
    step();
  endtask

  // Producer side: offer a token; when the model is full it must wait for one pop.
  task automatic send(input logic [3:0] v, input string tag);
    data_in = enc(v);
    if (model_q.size() >= DEPTH) begin
      for (int k = 0; k < 3; k++) begin
        step();
        chk({tag, " blocked ack"}, ack_ant, 0);
        chk({tag, " blocked count"}, count, DEPTH);
      end
      recv({tag, " drain"});
    end else begin
      step();
    end
    model_q.push_back(v);
    chk({tag, " ack"}, ack_ant, 1);
    chk({tag, " count"}, count, model_q.size());
    data_in = 8'($urandom_range(1, 255));
    step();
    chk({tag, " ack held"}, ack_ant, 1);
    chk({tag, " count held"}, count, model_q.size());
    data_in = 8'h00;
    step();
    chk({tag, " ack release"}, ack_ant, 0);
    chk({tag, " err"}, err_illegal, model_err);
  endtask

  initial begin
    rst_n      = 1'b0;
    data_in    = 8'h00;
    ack_next   = 1'b0;
    z_data_in  = 8'h00;
    z_ack_next = 1'b0;
    model_err  = 1'b0;
    model_q    = {};
    model_q.push_back(4'h0);

    step();
    step();
    chk("reset ack_ant", ack_ant, 0);
    chk("reset data_out", data_out, 8'h00);
    chk("reset count", count, 1);
    chk("reset err", err_illegal, 0);
    chk("reset z count", z_count, 0);

    // 1: preloaded token appears one edge after release.
    rst_n = 1'b1;
    step();
    chk("t1 data_out", data_out, 8'h55);
    chk("t1 count", count, 1);
    chk("t1 z data_out", z_data_out, 8'h00);

    // 2: empty FIFO latency, no bypass.
    z_data_in = 8'b10011001;
    step();
    chk("t2 ack", z_ack_ant, 1);
    chk("t2 count", z_count, 1);
    chk("t2 no bypass", z_data_out, 8'h00);
    z_data_in = 8'h00;
    step();
    chk("t2 ack release", z_ack_ant, 0);
    chk("t2 data_out", z_data_out, 8'b10011001);
    z_ack_next = 1'b1;
    step();
    chk("t2 spacer", z_data_out, 8'h00);
    chk("t2 count empty", z_count, 0);
    z_ack_next = 1'b0;
    step();

    // 3: fill to full, blocked push, order 0,1,2,3,4.
    send(4'h1, "t3 push1");
    send(4'h2, "t3 push2");
    send(4'h3, "t3 push3");
    chk("t3 full count", count, 4);
    send(4'h4, "t3 push4");
    for (int k = 0; k < 4; k++) recv("t3 pop");
    chk("t3 empty", count, 0);

    // 4: partial codeword is not captured.
    data_in = 8'b10000001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4 partial ack", ack_ant, 0);
      chk("t4 partial count", count, 0);
    end
    send(4'h8, "t4 push8");
    recv("t4 pop8");

    // 5: illegal pair sets the sticky flag without a push.
    data_in = 8'b11010101;
    step();
    model_err = 1'b1;
    chk("t5 err", err_illegal, 1);
    chk("t5 ack", ack_ant, 0);
    chk("t5 count", count, 0);
    step();
    chk("t5 err hold", err_illegal, 1);
    send(4'hC, "t5 legal");
    recv("t5 pop");

    // Random traffic against the queue model.
    for (int r = 0; r < 30; r++) begin
      if (model_q.size() > 0 && $urandom_range(0, 1) == 1) recv("rnd recv");
      else send(4'($urandom_range(0, 15)), "rnd send");
      repeat ($urandom_range(0, 2)) step();
    end

    // 6: reset mid-handshake on both sides.
    if (model_q.size() >= DEPTH) recv("t6 make room");
    data_in = enc(4'h9);
    step();
    chk("t6 ack", ack_ant, 1);
    step();
    chk("t6 out presenting", is_cw(data_out), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 async ack", ack_ant, 0);
    chk("t6 async data_out", data_out, 8'h00);
    chk("t6 async count", count, 1);
    chk("t6 async err", err_illegal, 0);
    data_in = 8'h00;
    step();
    rst_n = 1'b1;
    model_q   = {};
    model_q.push_back(4'h0);
    model_err = 1'b0;
    step();
    chk("t6 preload out", data_out, 8'h55);
    chk("t6 count", count, 1);
    recv("t6 pop preload");
    send(4'h6, "t6 push");
    recv("t6 pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
